// File: rtl/fetch_prefetch.sv
// Fetch stage: PC, credit-limited requests to a variable-latency instruction memory,
// a DEPTH-entry prefetch queue and the IF/ID register with stall, redirect and valid.
module fetch_prefetch #(
  parameter int          IW       = 20,
  parameter int          AW       = 15,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_e,
  input  logic [AW-1:0]              redirect_pc_e,
  input  logic                       stall_d,
  output logic                       imem_req,
  output logic [AW-1:0]              imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [IW-1:0]              imem_rdata,
  output logic [IW-1:0]              instr_d,
  output logic [AW-1:0]              pc_d,
  output logic                       valid_d,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int SW = CW + 1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [IW-1:0] instr_q, instr_nxt;
  logic [AW-1:0] pcd_q, pcd_nxt;
  logic          vld_q, vld_nxt;

  logic [IW-1:0] data_q [DEPTH];
  logic [AW-1:0] qpc_q  [DEPTH];
  logic [AW-1:0] tag_q  [DEPTH];

  logic acc, rv, push, pop;

  // Credits count both queued and in-flight entries, so a push always has a slot.
  assign imem_req  = ~reset & (({1'b0, cnt_q} + {1'b0, outst_q}) < SW'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign acc       = imem_req & imem_gnt;
  assign rv        = imem_rvalid & (outst_q != '0);
  assign push      = rv & (drop_q == '0) & ~redirect_e;
  assign pop       = ~redirect_e & ~stall_d & (cnt_q != '0);

  assign instr_d = instr_q;
  assign pc_d    = pcd_q;
  assign valid_d = vld_q;
  assign q_count = cnt_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q + CW'(acc) - CW'(rv);
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    tag_wr_d   = acc ? ptr_inc(tag_wr_q) : tag_wr_q;
    tag_rd_d   = rv  ? ptr_inc(tag_rd_q) : tag_rd_q;
    instr_nxt  = instr_q;
    pcd_nxt    = pcd_q;
    vld_nxt    = vld_q;

    if (redirect_e) begin
      fetch_pc_d = redirect_pc_e;
    end else if (acc) begin
      fetch_pc_d = fetch_pc_q + 1'b1;
    end

    if (redirect_e) begin
      // Everything still in flight, including this cycle's request, is stale.
      drop_d    = outst_d;
      cnt_d     = '0;
      head_d    = '0;
      tail_d    = '0;
      instr_nxt = '0;
      vld_nxt   = 1'b0;
    end else begin
      if (rv && drop_q != '0) drop_d = drop_q - 1'b1;
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (!stall_d) begin
        if (pop) begin
          instr_nxt = data_q[head_q];
          pcd_nxt   = qpc_q[head_q];
          vld_nxt   = 1'b1;
        end else begin
          instr_nxt = '0;
          vld_nxt   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= AW'(RESET_PC);
      outst_q    <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      instr_q    <= '0;
      pcd_q      <= '0;
      vld_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      instr_q    <= instr_nxt;
      pcd_q      <= pcd_nxt;
      vld_q      <= vld_nxt;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is live.
  always_ff @(posedge clk) begin
    if (acc) tag_q[tag_wr_q] <= fetch_pc_q;
    if (push) begin
      data_q[tail_q] <= imem_rdata;
      qpc_q[tail_q]  <= tag_q[tag_rd_q];
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid && outst_q == '0));

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with an in-order fixed-latency memory model
// returning mem[a] = a + 0x100.
module tb_fetch_prefetch;
  localparam int IW = 20;
  localparam int AW = 15;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          redirect_e;
  logic [AW-1:0] redirect_pc_e;
  logic          stall_d;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] instr_d;
  logic [AW-1:0] pc_d;
  logic          valid_d;
  logic [2:0]    q_count;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 1;
  int cyc     = 0;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } req_t;
  req_t pend[$];

  always #5 clk = ~clk;

  fetch_prefetch #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .redirect_e(redirect_e), .redirect_pc_e(redirect_pc_e),
    .stall_d(stall_d), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_d(instr_d), .pc_d(pc_d),
    .valid_d(valid_d), .q_count(q_count)
  );

  // Memory model: accepted requests are sampled mid-cycle, answered lat cycles later.
  always @(negedge clk) begin
    if (reset) pend.delete();
    else if (imem_req && imem_gnt) pend.push_back('{imem_addr, cyc + lat});
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (reset) begin
      pend.delete();
    end else if (pend.size() > 0 && pend[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = IW'(pend[0].addr) + 20'h100;
      void'(pend.pop_front());
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [AW-1:0] p,
                           input logic [IW-1:0] ins);
    check({tag, "_valid"}, 32'(valid_d), 32'(v));
    check({tag, "_pc"},    32'(pc_d),    32'(p));
    check({tag, "_instr"}, 32'(instr_d), 32'(ins));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    redirect_e    = 1'b0;
    redirect_pc_e = '0;
    stall_d       = 1'b0;
    imem_gnt      = 1'b1;
    imem_rvalid   = 1'b0;
    imem_rdata    = '0;
    step();
    step();

    // Reset values
    check("rst_req",   32'(imem_req),  0);
    check("rst_addr",  32'(imem_addr), 0);
    check("rst_qcnt",  32'(q_count),   0);
    check_out("rst", 1'b0, 15'h0, 20'h0);

    // Streaming with a 1-cycle memory
    reset = 1'b0;
    #1;
    check("first_req",  32'(imem_req),  1);
    check("first_addr", 32'(imem_addr), 0);
    step();
    check("lat_n1_valid", 32'(valid_d), 0);
    step();
    check("lat_n2_valid", 32'(valid_d), 0);
    step();
    for (int k = 0; k < 6; k++) begin
      check_out("stream", 1'b1, AW'(k), 20'h100 + IW'(k));
      if (k < 5) step();
    end

    // Decode stall for six cycles
    stall_d = 1'b1;
    step();
    check_out("stall_s1", 1'b1, 15'h5, 20'h105);
    step();
    check("stall_noreq", 32'(imem_req), 0);
    step();
    check("stall_qfull", 32'(q_count), 4);
    check("stall_qfull_req", 32'(imem_req), 0);
    step();
    step();
    check_out("stall_s5", 1'b1, 15'h5, 20'h105);
    step();
    stall_d = 1'b0;
    step();
    for (int k = 6; k < 14; k++) begin
      check_out("resume", 1'b1, AW'(k), 20'h100 + IW'(k));
      step();
    end

    // Redirect with two responses outstanding on a 3-cycle memory
    reset = 1'b1;
    lat   = 3;
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check_out("pre_redir", 1'b1, 15'h0, 20'h100);
    check("pre_redir_qcnt", 32'(q_count), 1);
    redirect_e    = 1'b1;
    redirect_pc_e = 15'h040;
    step();
    redirect_e = 1'b0;
    check("redir_valid", 32'(valid_d),   0);
    check("redir_instr", 32'(instr_d),   0);
    check("redir_qcnt",  32'(q_count),   0);
    check("redir_req",   32'(imem_req),  1);
    check("redir_addr",  32'(imem_addr), 32'h40);
    for (int k = 0; k < 4; k++) begin
      step();
      check("redir_bubble", 32'(valid_d), 0);
    end
    step();
    check_out("redir_t0", 1'b1, 15'h040, 20'h140);
    step();
    check_out("redir_t1", 1'b1, 15'h041, 20'h141);
    step();
    check_out("redir_t2", 1'b1, 15'h042, 20'h142);

    // Redirect and stall together
    stall_d       = 1'b1;
    redirect_e    = 1'b1;
    redirect_pc_e = 15'h200;
    step();
    redirect_e = 1'b0;
    check("rs_valid", 32'(valid_d),   0);
    check("rs_instr", 32'(instr_d),   0);
    check("rs_qcnt",  32'(q_count),   0);
    check("rs_addr",  32'(imem_addr), 32'h200);
    stall_d = 1'b0;

    // PC wrap at 0x7FFF
    reset = 1'b1;
    lat   = 1;
    step();
    reset         = 1'b0;
    redirect_e    = 1'b1;
    redirect_pc_e = 15'h7FFF;
    step();
    redirect_e = 1'b0;
    check("wrap_addr_hi", 32'(imem_addr), 32'h7FFF);
    step();
    check("wrap_addr_lo", 32'(imem_addr), 0);
    step();
    step();
    check_out("wrap_pc_hi", 1'b1, 15'h7FFF, 20'h80FF);
    step();
    check_out("wrap_pc_lo", 1'b1, 15'h0000, 20'h100);
    step();
    check_out("wrap_pc_1", 1'b1, 15'h0001, 20'h101);

    // Reset mid-stream with three queued entries
    stall_d = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (q_count == 3'd3) break;
      step();
    end
    check("mid_q3", 32'(q_count), 3);
    reset = 1'b1;
    #1;
    check("mid_rst_req",  32'(imem_req),  0);
    check("mid_rst_addr", 32'(imem_addr), 0);
    check("mid_rst_qcnt", 32'(q_count),   0);
    check_out("mid_rst", 1'b0, 15'h0, 20'h0);
    step();
    reset   = 1'b0;
    stall_d = 1'b0;
    #1;
    check("post_rst_req",  32'(imem_req),  1);
    check("post_rst_addr", 32'(imem_addr), 0);
    step();
    step();
    step();
    check_out("post_rst_first", 1'b1, 15'h0, 20'h100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
